// File: rtl/bsg_activation_sequencer.sv
// Activation sequencer: accepts a vector command, streams its elements one at
// a time through an external tanh/sigmoid unit, and returns the results in order.
//
// Handshakes: each channel moves one item on a cycle where its valid and ready
// are both high at the rising clock edge (out_yumi_i plays that role for the
// out channel). Valid outputs never depend combinationally on the matching
// ready input. The data on an asserted valid output stays stable until it is
// taken.
module bsg_activation_sequencer #(
  parameter int ang_width_p = 20,
  parameter int ans_width_p = 32,
  parameter int precision_p = 16,
  parameter int max_els_p   = 16,
  localparam int lg_els_lp  = (max_els_p > 1) ? $clog2(max_els_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  // command channel
  input  logic                   cmd_v_i,
  output logic                   cmd_ready_o,
  input  logic [lg_els_lp-1:0]   cmd_len_i,
  input  logic                   cmd_tanh_i,
  // element input channel
  input  logic                   in_v_i,
  output logic                   in_ready_o,
  input  logic [ang_width_p-1:0] in_data_i,
  // activation unit request / response
  output logic [ang_width_p-1:0] act_ang_o,
  output logic                   act_tanh_sel_o,
  output logic                   act_neg_sel_o,
  output logic                   act_val_o,
  input  logic                   act_ready_i,
  input  logic [ans_width_p-1:0] act_data_i,
  input  logic                   act_val_i,
  output logic                   act_ready_o,
  // result channel
  output logic                   out_v_o,
  output logic [ans_width_p-1:0] out_data_o,
  output logic                   out_last_o,
  input  logic                   out_yumi_i,
  output logic                   done_o,
  // debug view of the sequencer state
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  localparam logic [ang_width_p-1:0] ang_min_lp = {1'b1, {(ang_width_p-1){1'b0}}};
  localparam logic [ang_width_p-1:0] ang_max_lp = {1'b0, {(ang_width_p-1){1'b1}}};

  state_e                 state_q, state_d;
  logic [lg_els_lp-1:0]   len_q, len_d;
  logic [lg_els_lp-1:0]   cnt_q, cnt_d;
  logic                   tanh_q, tanh_d;
  logic [ang_width_p-1:0] ang_q, ang_d;
  logic                   neg_q, neg_d;
  logic [ans_width_p-1:0] res_q, res_d;
  logic                   done_q, done_d;

  logic [ang_width_p-1:0] in_mag;
  logic                   is_last;

  // Magnitude of the incoming element; the most negative code has no positive
  // twin, so it clamps to the largest positive value.
  always_comb begin
    in_mag = in_data_i;
    if (in_data_i == ang_min_lp) begin
      in_mag = ang_max_lp;
    end else if (in_data_i[ang_width_p-1]) begin
      in_mag = -in_data_i;
    end
  end

  assign is_last = (cnt_q == len_q);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tanh_q  <= 1'b0;
      ang_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tanh_q  <= tanh_d;
      ang_q   <= ang_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tanh_d      = tanh_q;
    ang_d       = ang_q;
    neg_d       = neg_q;
    res_d       = res_q;
    done_d      = 1'b0;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    act_val_o   = 1'b0;
    act_ready_o = 1'b0;
    out_v_o     = 1'b0;
    out_last_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) begin
          len_d   = cmd_len_i;
          tanh_d  = cmd_tanh_i;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_v_i) begin
          ang_d   = in_mag;
          neg_d   = in_data_i[ang_width_p-1];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        act_val_o = 1'b1;
        if (act_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        act_ready_o = 1'b1;
        if (act_val_i) begin
          // tanh is odd, so a negative input flips the unit's result; sigmoid
          // symmetry is already handled inside the unit.
          res_d   = (tanh_q && neg_q) ? -act_data_i : act_data_i;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_v_o    = 1'b1;
        out_last_o = is_last;
        if (out_yumi_i) begin
          if (is_last) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + lg_els_lp'(1);
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign act_ang_o      = ang_q;
  assign act_neg_sel_o  = neg_q;
  assign act_tanh_sel_o = tanh_q;
  assign out_data_o     = res_q;
  assign done_o         = done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_bsg_activation_sequencer.sv
// Bench for bsg_activation_sequencer: directed scenarios followed by random
// vectors, with the activation unit and the result consumer played by the
// bench and results predicted by a reference model.
module tb_bsg_activation_sequencer;

  localparam int AW = 20;
  localparam int RW = 32;
  localparam int ME = 16;
  localparam int LG = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          cmd_v, cmd_ready, cmd_tanh;
  logic [LG-1:0] cmd_len;
  logic          in_v, in_ready;
  logic [AW-1:0] in_data;
  logic [AW-1:0] act_ang;
  logic          act_tanh_sel, act_neg_sel, act_val_o, act_ready_i;
  logic [RW-1:0] act_data;
  logic          act_val_i, act_ready_o;
  logic          out_v, out_last, out_yumi, done;
  logic [RW-1:0] out_data;
  logic [2:0]    state_dbg;

  bsg_activation_sequencer #(
    .ang_width_p(AW), .ans_width_p(RW), .precision_p(16), .max_els_p(ME)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len), .cmd_tanh_i(cmd_tanh),
    .in_v_i(in_v), .in_ready_o(in_ready), .in_data_i(in_data),
    .act_ang_o(act_ang), .act_tanh_sel_o(act_tanh_sel), .act_neg_sel_o(act_neg_sel),
    .act_val_o(act_val_o), .act_ready_i(act_ready_i), .act_data_i(act_data),
    .act_val_i(act_val_i), .act_ready_o(act_ready_o),
    .out_v_o(out_v), .out_data_o(out_data), .out_last_o(out_last),
    .out_yumi_i(out_yumi), .done_o(done), .state_o(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  logic [AW-1:0] vdata[ME];
  logic [RW-1:0] rdata[ME];
  int stall_el;
  int stall_n;
  int act_hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: |x| clamped to the largest positive AW-bit value.
  function automatic logic [AW-1:0] ref_ang(input logic [AW-1:0] x);
    longint v;
    longint lim;
    v = longint'($signed(x));
    lim = (longint'(1) << (AW - 1)) - 1;
    if (v < 0) v = -v;
    if (v > lim) v = lim;
    return v[AW-1:0];
  endfunction

  // Reference model: tanh of a negative input is the negated unit result mod 2^RW.
  function automatic logic [RW-1:0] ref_out(input bit tanh, input logic [AW-1:0] x,
                                            input logic [RW-1:0] d);
    longint t;
    if (tanh && ($signed(x) < 0)) begin
      t = (longint'(1) << RW) - longint'({32'b0, d});
      return t[RW-1:0];
    end
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int len, input bit tanh);
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_v = 1'b1;
    cmd_len = LG'(len);
    cmd_tanh = tanh;
    tick();
    cmd_v = 1'b0;
    cmd_len = LG'($urandom);
    check("busy_cmd_ready", cmd_ready, 0);
    check("first_in_ready", in_ready, 1);
  endtask

  task automatic do_element(input int i, input int len, input bit tanh, input bit abort_in_wait);
    logic [AW-1:0] x;
    logic [AW-1:0] ea;
    logic          en;
    logic [RW-1:0] eo;
    int n;
    x  = vdata[i];
    ea = ref_ang(x);
    en = ($signed(x) < 0);
    check("load_in_ready", in_ready, 1);
    check("load_act_val", act_val_o, 0);
    in_v = 1'b1;
    in_data = x;
    tick();
    in_v = 1'b0;
    in_data = AW'($urandom);
    exp_q.push_back(ref_out(tanh, x, rdata[i]));
    check("issue_act_val", act_val_o, 1);
    check("issue_ang", act_ang, ea);
    check("issue_neg", act_neg_sel, en);
    check("issue_tanh", act_tanh_sel, tanh);
    check("issue_in_ready", in_ready, 0);
    check("issue_cmd_ready", cmd_ready, 0);
    act_ready_i = 1'b0;
    for (int k = 0; k < act_hold; k++) begin
      tick();
      check("hold_act_val", act_val_o, 1);
      check("hold_ang", act_ang, ea);
      check("hold_neg", act_neg_sel, en);
      check("hold_tanh", act_tanh_sel, tanh);
    end
    act_ready_i = 1'b1;
    tick();
    act_ready_i = 1'b0;
    check("wait_act_val", act_val_o, 0);
    check("wait_act_ready", act_ready_o, 1);
    check("wait_ang", act_ang, ea);
    check("wait_neg", act_neg_sel, en);
    if (abort_in_wait) return;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      tick();
      check("wait_hold_ready", act_ready_o, 1);
      check("wait_out_v", out_v, 0);
    end
    act_val_i = 1'b1;
    act_data = rdata[i];
    tick();
    act_val_i = 1'b0;
    act_data = RW'($urandom);
    eo = exp_q.pop_front();
    check("out_v", out_v, 1);
    check("out_act_ready", act_ready_o, 0);
    check("out_data", out_data, eo);
    check("out_last", out_last, (i == len));
    n = (i == stall_el) ? stall_n : $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      tick();
      check("stall_out_v", out_v, 1);
      check("stall_out_data", out_data, eo);
      check("stall_in_ready", in_ready, 0);
      check("stall_act_val", act_val_o, 0);
    end
    out_yumi = 1'b1;
    tick();
    out_yumi = 1'b0;
    if (i == len) begin
      check("done_pulse", done, 1);
      check("end_cmd_ready", cmd_ready, 1);
      check("end_out_v", out_v, 0);
      tick();
      check("done_clear", done, 0);
    end else begin
      check("next_in_ready", in_ready, 1);
      check("next_done", done, 0);
    end
  endtask

  task automatic run_vec(input int len, input bit tanh);
    send_cmd(len, tanh);
    for (int i = 0; i <= len; i++) do_element(i, len, tanh, 1'b0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < ME; i++) begin
      case ($urandom_range(0, 5))
        0: vdata[i] = {1'b1, {(AW-1){1'b0}}};
        1: vdata[i] = {1'b0, {(AW-1){1'b1}}};
        default: vdata[i] = AW'($urandom);
      endcase
      rdata[i] = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
    end
  endtask

  // ---------------- directed and random steps ----------------
  initial begin
    reset_n = 1'b0;
    cmd_v = 1'b0; cmd_len = '0; cmd_tanh = 1'b0;
    in_v = 1'b0; in_data = '0;
    act_ready_i = 1'b0; act_val_i = 1'b0; act_data = '0;
    out_yumi = 1'b0;
    stall_el = -1; stall_n = 0; act_hold = 0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_act_val", act_val_o, 0);
    check("rst_act_ready", act_ready_o, 0);
    check("rst_out_v", out_v, 0);
    check("rst_done", done, 0);
    check("rst_ang", act_ang, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // sigmoid of zero, single element
    vdata[0] = 20'h00000; rdata[0] = 32'h0000_8000;
    run_vec(0, 1'b0);

    // tanh of -0.5
    vdata[0] = 20'hF8000; rdata[0] = 32'h0000_763C;
    run_vec(0, 1'b1);

    // sigmoid of most-negative input
    vdata[0] = 20'h80000; rdata[0] = 32'h0000_1234;
    run_vec(0, 1'b0);

    // four elements, consumer stalls five cycles on element 2
    fill_random();
    stall_el = 2; stall_n = 5;
    run_vec(3, 1'b1);
    stall_el = -1;

    // unit holds off the request for ten cycles
    fill_random();
    act_hold = 10;
    run_vec(0, 1'b1);
    act_hold = 0;

    // full-length vector
    fill_random();
    run_vec(ME - 1, 1'b0);

    // reset while waiting on the unit, with a command pushed during busy
    fill_random();
    send_cmd(2, 1'b1);
    cmd_v = 1'b1; cmd_len = '0; cmd_tanh = 1'b0;
    do_element(0, 2, 1'b1, 1'b1);
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    check("arst_act_ready", act_ready_o, 0);
    check("arst_act_val", act_val_o, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_v", out_v, 0);
    check("arst_done", done, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_ang", act_ang, 0);
    tick();
    check("arst_hold_in_ready", in_ready, 0);
    reset_n = 1'b1;
    tick();
    cmd_v = 1'b0;
    check("post_rst_accept", in_ready, 1);
    check("post_rst_cmd_ready", cmd_ready, 0);
    vdata[0] = 20'h0ABCD; rdata[0] = 32'h0000_5555;
    do_element(0, 0, 1'b0, 1'b0);

    // random vectors
    for (int v = 0; v < 12; v++) begin
      fill_random();
      act_hold = $urandom_range(0, 3);
      run_vec($urandom_range(0, ME - 1), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
